// File: rtl/laser_pulse_sched.sv
// Round-robin scheduler sharing one laser driver: each grant fires one pulse of
// PULSE_LEN cycles followed by COOL_LEN forced-off cycles.
module laser_pulse_sched #(
  parameter int N_REQ     = 4,
  parameter int PULSE_LEN = 3,
  parameter int COOL_LEN  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic                     abort,
  output logic                     x,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic [N_REQ-1:0]         done,
  output logic                     aborted
);

  localparam int GW       = $clog2(N_REQ);
  localparam int MAX_LEN  = (PULSE_LEN > COOL_LEN) ? PULSE_LEN : COOL_LEN;
  localparam int CW       = $clog2(MAX_LEN + 1);
  localparam bit HAS_COOL = (COOL_LEN > 0);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] COOL_LOAD  = CW'(HAS_COOL ? COOL_LEN - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    COOL
  } state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     counter_reg, counter_next;
  logic [N_REQ-1:0]  pending_reg, pending_next;
  logic [GW-1:0]     last_grant_reg, last_grant_next;
  logic              x_next;
  logic              busy_next;
  logic [GW-1:0]     grant_id_next;
  logic [N_REQ-1:0]  done_next;
  logic              aborted_next;

  logic [N_REQ-1:0]  cand;
  logic [GW-1:0]     pick;
  logic              pick_found;
  logic [GW-1:0]     arb_idx;
  logic [N_REQ-1:0]  pick_onehot;
  logic [N_REQ-1:0]  grant_onehot;

  // A request seen on the arbitration edge counts even before it is latched.
  assign cand = pending_reg | req;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_onehot
      assign pick_onehot[gi]  = (pick == GW'(gi));
      assign grant_onehot[gi] = (grant_id == GW'(gi));
    end
  endgenerate

  // Scan from last_grant+1 with wrap; iterating backwards lets the nearest
  // candidate overwrite any farther one.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    arb_idx    = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      arb_idx = GW'((int'(last_grant_reg) + off) % N_REQ);
      if (cand[arb_idx]) begin
        pick       = arb_idx;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    counter_next    = counter_reg;
    pending_next    = pending_reg | req;
    last_grant_next = last_grant_reg;
    grant_id_next   = grant_id;
    x_next          = x;
    busy_next       = busy;
    done_next       = '0;
    aborted_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        x_next    = 1'b0;
        busy_next = 1'b0;
        if (pick_found) begin
          // The grant consumes the winner's request, latched or live.
          pending_next    = cand & ~pick_onehot;
          grant_id_next   = pick;
          last_grant_next = pick;
          x_next          = 1'b1;
          busy_next       = 1'b1;
          counter_next    = PULSE_LOAD;
          state_next      = FIRE;
        end
      end

      FIRE: begin
        if (abort || (counter_reg == '0)) begin
          x_next = 1'b0;
          if (abort) begin
            aborted_next = 1'b1;
          end else begin
            done_next = grant_onehot;
          end
          if (HAS_COOL) begin
            counter_next = COOL_LOAD;
            state_next   = COOL;
          end else begin
            busy_next  = 1'b0;
            state_next = IDLE;
          end
        end else begin
          counter_next = counter_reg - 1'b1;
        end
      end

      COOL: begin
        x_next = 1'b0;
        if (counter_reg == '0) begin
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          counter_next = counter_reg - 1'b1;
        end
      end

      default: begin
        x_next     = 1'b0;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      counter_reg    <= '0;
      pending_reg    <= '0;
      last_grant_reg <= GW'(N_REQ - 1);
      grant_id       <= '0;
      x              <= 1'b0;
      busy           <= 1'b0;
      done           <= '0;
      aborted        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      counter_reg    <= counter_next;
      pending_reg    <= pending_next;
      last_grant_reg <= last_grant_next;
      grant_id       <= grant_id_next;
      x              <= x_next;
      busy           <= busy_next;
      done           <= done_next;
      aborted        <= aborted_next;
    end
  end

endmodule
